// File: rtl/io_port_arbiter.sv
// io_port_arbiter: round-robin arbiter that lets two masters share one single-beat I/O register slave.
//   M0 = CPU and M1 = DMA/hypervisor. Each transaction takes 4 cycles: IDLE -> ISSUE -> WAIT -> DONE.
//   Every output is registered. A request that loses arbitration is held off until the next IDLE.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   m0_* / m1_*     master ports: req, addr, we, wdata in; rdata and a 1-cycle ack pulse out
//   s_cs, s_ready   1-cycle select/write-qualifier strobe to the slave (always equal)
//   s_addr/we/wdata command latched at grant, held from ISSUE through DONE
//   s_rdata, s_ack  slave read data and its registered completion
//   timeout         1-cycle pulse in DONE when a transaction was force-completed
// Optional feature: define IOARB_TIMEOUT_EN to force completion (rdata=8'hFF) after
//   TIMEOUT_CYCLES cycles in WAIT. Without it, WAIT holds until s_ack and timeout is tied to 0.
module io_port_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [7:0]        m0_wdata,
  output logic [7:0]        m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [7:0]        m1_wdata,
  output logic [7:0]        m1_rdata,
  output logic              m1_ack,
  output logic              s_cs,
  output logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_we,
  output logic [7:0]        s_wdata,
  input  logic [7:0]        s_rdata,
  input  logic              s_ack,
  output logic              timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("io_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   last_grant;  // 0 = M0, 1 = M1
  logic   grant;       // master that owns the current transaction
  logic   pick;        // arbitration result, used only in IDLE
  logic [7:0] ack_data;

  // A lone requester always wins. On a tie, the master that was not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) pick = ~last_grant;
    else if (m1_req)      pick = 1'b1;
  end

  // Writes return zero data to the master.
  assign ack_data = s_we ? 8'h00 : s_rdata;

`ifdef IOARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      s_cs       <= 1'b0;
      s_ready    <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= 8'h00;
      m0_rdata   <= 8'h00;
      m1_rdata   <= 8'h00;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
`ifdef IOARB_TIMEOUT_EN
      timeout    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant      <= pick;
            last_grant <= pick;
            s_addr     <= pick ? m1_addr  : m0_addr;
            s_we       <= pick ? m1_we    : m0_we;
            s_wdata    <= pick ? m1_wdata : m0_wdata;
            // Raised here so that the registered strobe is visible during ISSUE.
            s_cs       <= 1'b1;
            s_ready    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          s_cs    <= 1'b0;
          s_ready <= 1'b0;
`ifdef IOARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state   <= WAIT;
        end
        WAIT: begin
          // An s_ack in the final counted cycle takes priority over expiry.
          if (s_ack) begin
            if (grant) begin
              m1_rdata <= ack_data;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= ack_data;
              m0_ack   <= 1'b1;
            end
            state <= DONE;
          end
`ifdef IOARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            if (grant) begin
              m1_rdata <= 8'hFF;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= 8'hFF;
              m0_ack   <= 1'b1;
            end
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
`ifdef IOARB_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Testbench for io_port_arbiter. Directed stimulus pushes the expected slave commands and
// master completions into queues. A monitor running on the falling edge pops and compares them.
// It includes a small model of the CPU-port slave: $00 = DDR (reset 00), $01 = value (reset 3F).
module tb_io_port_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]    m0_wdata = 0, m1_wdata = 0;
  logic [7:0]    m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic          s_cs, s_ready, s_we, s_ack, timeout;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_wdata, s_rdata;

  always #5 clk = ~clk;

  io_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_cs(s_cs), .s_ready(s_ready), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model. slave_en=0 suppresses the ack. late_cyc forces an s_ack in that cycle.
  logic [7:0] ddr, port;
  logic       slave_en = 1'b1;
  int         late_cyc = -10;
  always @(posedge clk) begin
    if (reset) begin
      ddr <= 8'h00; port <= 8'h3F; s_ack <= 1'b0; s_rdata <= 8'h00;
    end else begin
      s_ack   <= (s_cs && slave_en) || (cyc == late_cyc - 1);
      s_rdata <= s_addr[0] ? port : ddr;
      if (s_cs && s_ready && s_we) begin
        if (s_addr[0]) port <= s_wdata;
        else           ddr  <= s_wdata;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic m; logic [7:0] rd; logic tmo; int at; } exp_t;
  typedef struct { logic [AW-1:0] a; logic we; logic [7:0] wd; } iss_t;
  exp_t sb[$];
  iss_t iq[$];

  // Monitor.
  logic          prev_cs = 1'b0;
  logic [AW-1:0] last_addr = '0;
  exp_t          e;
  iss_t          is;
  always @(negedge clk) begin
    if (s_cs) begin
      chk("cs_single_cycle", prev_cs, 1'b0);
      chk("ready_eq_cs", s_ready, 1'b1);
      chk("issue_expected", iq.size() > 0, 1'b1);
      if (iq.size() > 0) begin
        is = iq.pop_front();
        chk("issue_addr", s_addr, is.a);
        chk("issue_we", s_we, is.we);
        if (is.we) chk("issue_wdata", s_wdata, is.wd);
        last_addr = s_addr;
      end
    end
    if (m0_ack || m1_ack) begin
      chk("ack_onehot", m0_ack && m1_ack, 1'b0);
      chk("ack_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ack_master", m1_ack, e.m);
        chk("ack_rdata", e.m ? m1_rdata : m0_rdata, e.rd);
        chk("ack_timeout", timeout, e.tmo);
        chk("ack_cycle", cyc, e.at);
        chk("addr_stable", s_addr, last_addr);
      end
    end else if (timeout) begin
      chk("stray_timeout", timeout, 1'b0);
    end
    prev_cs = s_cs;
  end

  task automatic drive(input logic m, input logic [AW-1:0] a, input logic we, input logic [7:0] wd);
    if (m) begin m1_req = 1; m1_addr = a; m1_we = we; m1_wdata = wd; end
    else   begin m0_req = 1; m0_addr = a; m0_we = we; m0_wdata = wd; end
  endtask

  task automatic expect_txn(input logic m, input logic [AW-1:0] a, input logic we,
                            input logic [7:0] wd, input logic [7:0] rd, input logic tmo, input int at);
    iq.push_back('{a: a, we: we, wd: wd});
    sb.push_back('{m: m, rd: rd, tmo: tmo, at: at});
  endtask

  // Waits a bounded number of cycles for master m's ack, then drops its request in the ack cycle.
  task automatic wait_ack(input logic m);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (m ? m1_ack : m0_ack) begin
        seen = 1;
        if (m) m1_req = 0; else m0_req = 0;
      end
    end
    chk("ack_arrived", seen, 1'b1);
  endtask

  task automatic single(input logic m, input logic [AW-1:0] a, input logic we,
                        input logic [7:0] wd, input logic [7:0] rd);
    @(negedge clk);
    drive(m, a, we, wd);
    expect_txn(m, a, we, wd, rd, 1'b0, cyc + 3);
    wait_ack(m);
  endtask

  // Both masters request in the same cycle. 'first' is the master that should win.
  task automatic pair(input logic [AW-1:0] a0, input logic we0, input logic [7:0] wd0, input logic [7:0] rd0,
                      input logic [AW-1:0] a1, input logic we1, input logic [7:0] wd1, input logic [7:0] rd1,
                      input logic first);
    int n;
    @(negedge clk);
    n = cyc;
    drive(0, a0, we0, wd0);
    drive(1, a1, we1, wd1);
    if (first) begin
      expect_txn(1, a1, we1, wd1, rd1, 0, n + 3);
      expect_txn(0, a0, we0, wd0, rd0, 0, n + 7);
    end else begin
      expect_txn(0, a0, we0, wd0, rd0, 0, n + 3);
      expect_txn(1, a1, we1, wd1, rd1, 0, n + 7);
    end
    wait_ack(first);
    wait_ack(~first);
  endtask

  task automatic check_reset();
    chk("rst_ctrl", {s_cs, s_ready, s_we, m0_ack, m1_ack, timeout}, 6'b0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_m_rdata", {m0_rdata, m1_rdata}, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    check_reset();
    reset = 0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 0;

    // Single M0 write to DDR, followed by a readback.
    single(0, 8'h00, 1, 8'h2F, 8'h00);
    chk("slave_ddr", ddr, 8'h2F);
    single(0, 8'h00, 0, 8'h00, 8'h2F);

    // M1 read of the port value immediately after reset.
    do_reset();
    single(1, 8'h01, 0, 8'h00, 8'h3F);

    // Tie after reset: M0 wins because last_grant resets to M1.
    do_reset();
    pair(8'h01, 0, 8'h00, 8'h3F, 8'h01, 1, 8'h55, 8'h00, 1'b0);
    // A lone M0 transaction moves last_grant to M0, so M1 wins the next tie.
    single(0, 8'h01, 0, 8'h00, 8'h55);
    pair(8'h00, 1, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1);

    // Both requests held continuously: grants alternate every 4 cycles, starting with M1.
    @(negedge clk);
    n = cyc;
    drive(0, 8'h00, 0, 8'h00);
    drive(1, 8'h01, 0, 8'h00);
    expect_txn(1, 8'h01, 0, 0, 8'h55, 0, n + 3);
    expect_txn(0, 8'h00, 0, 0, 8'hA5, 0, n + 7);
    expect_txn(1, 8'h01, 0, 0, 8'h55, 0, n + 11);
    expect_txn(0, 8'h00, 0, 0, 8'hA5, 0, n + 15);
    repeat (15) @(negedge clk);
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    chk("alternate_drained", sb.size(), 0);

    // Reset during WAIT: no ack is issued, and the outputs return to reset values.
    @(negedge clk);
    drive(0, 8'h01, 1, 8'h77);
    iq.push_back('{a: 8'h01, we: 1'b1, wd: 8'h77});
    repeat (2) @(negedge clk);
    reset = 1; m0_req = 0;
    @(negedge clk);
    check_reset();
    reset = 0;
    repeat (8) @(negedge clk);
    single(0, 8'h01, 0, 8'h00, 8'h3F);

`ifdef IOARB_TIMEOUT_EN
    // Slave never acks: forced completion after 16 WAIT cycles.
    slave_en = 0;
    @(negedge clk);
    n = cyc;
    drive(1, 8'h01, 0, 8'h00);
    expect_txn(1, 8'h01, 0, 0, 8'hFF, 1, n + 18);
    wait_ack(1);
    // s_ack in the expiry cycle wins: real data and no timeout.
    @(negedge clk);
    n = cyc;
    late_cyc = n + 17;
    drive(0, 8'h01, 0, 8'h00);
    expect_txn(0, 8'h01, 0, 0, 8'h3F, 0, n + 18);
    wait_ack(0);
    slave_en = 1;
`else
    // Without the timeout feature, WAIT holds for as long as the slave stays silent.
    slave_en = 0;
    @(negedge clk);
    drive(0, 8'h00, 0, 8'h00);
    iq.push_back('{a: 8'h00, we: 1'b0, wd: 8'h00});
    repeat (40) @(negedge clk);
    chk("hold_no_ack", {m0_ack, m1_ack, timeout}, 3'b0);
    slave_en = 1;
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("iq_empty", iq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
